// File: rtl/wired_registers_file_lvt.sv
// Multi-port register file: one bank per write port, a live-value table picks the freshest bank on read.
// Read latency 1 cycle; INIT sweep clears all entries over DEPTH cycles; WIRED_RF_BYPASS_EN adds write-to-read forwarding.
module wired_registers_file_lvt #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int R_PORT_COUNT = 4,
  parameter int W_PORT_COUNT = 2,
  parameter int ZERO_REG     = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [R_PORT_COUNT-1:0][$clog2(DEPTH)-1:0]    raddr_i,
  output logic [R_PORT_COUNT-1:0][DATA_WIDTH-1:0]       rdata_o,
  input  logic [W_PORT_COUNT-1:0]                       we_i,
  input  logic [W_PORT_COUNT-1:0][$clog2(DEPTH)-1:0]    waddr_i,
  input  logic [W_PORT_COUNT-1:0][DATA_WIDTH-1:0]       wdata_i,
  output logic                                          init_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (W_PORT_COUNT > 1) ? $clog2(W_PORT_COUNT) : 1;

  typedef enum logic {INIT, READY} state_e;

  state_e                                  state_q, state_d;
  logic [AW-1:0]                           cnt_q, cnt_d;
  logic [R_PORT_COUNT-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] bank_q [W_PORT_COUNT][DEPTH];
  logic [LW-1:0]         lvt_q  [DEPTH];

  logic [W_PORT_COUNT-1:0]                 bwe_d;
  logic [W_PORT_COUNT-1:0][AW-1:0]         bwaddr_d;
  logic [W_PORT_COUNT-1:0][DATA_WIDTH-1:0] bwdat_d;
  logic [W_PORT_COUNT-1:0][LW-1:0]         lvt_val_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      else                         cnt_d   = cnt_q + 1'b1;
    end
  end

  // In INIT every bank clears the swept address and the LVT points it at bank 0.
  always_comb begin
    bwe_d     = '0;
    bwaddr_d  = '0;
    bwdat_d   = '0;
    lvt_val_d = '0;
    if (state_q == INIT) begin
      bwe_d = '1;
      for (int w = 0; w < W_PORT_COUNT; w++) bwaddr_d[w] = cnt_q;
    end else begin
      for (int w = 0; w < W_PORT_COUNT; w++) begin
        if (we_i[w] && !is_zero(waddr_i[w])) begin
          bwe_d[w]     = 1'b1;
          bwaddr_d[w]  = waddr_i[w];
          bwdat_d[w]   = wdata_i[w];
          lvt_val_d[w] = LW'(w);
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (state_q == READY) begin
      for (int r = 0; r < R_PORT_COUNT; r++) begin
        if (!is_zero(raddr_i[r])) rdata_d[r] = bank_q[lvt_q[raddr_i[r]]][raddr_i[r]];
`ifdef WIRED_RF_BYPASS_EN
        // Ascending scan: the highest write port hitting this address wins.
        for (int w = 0; w < W_PORT_COUNT; w++) begin
          if (bwe_d[w] && (bwaddr_d[w] == raddr_i[r])) rdata_d[r] = bwdat_d[w];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Later ports overwrite earlier ones in the LVT when addresses collide.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int w = 0; w < W_PORT_COUNT; w++) begin
        if (bwe_d[w]) begin
          bank_q[w][bwaddr_d[w]] <= bwdat_d[w];
          lvt_q[bwaddr_d[w]]     <= lvt_val_d[w];
        end
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign init_done_o = (state_q == READY);

endmodule
